// File: rtl/sbus_tx_scheduler.sv
// sbus_tx_scheduler: shares one uart_tx between a byte-echo path and a periodic SBUS frame replayer.
// Define SBUS_FAILSAFE_EN to force the frame-lost/failsafe flags in byte 23 after FAILSAFE_FRAMES silent periods.
module sbus_tx_scheduler #(
   parameter int CLK_HZ          = 50000000,
   parameter int FRAME_PERIOD_US = 14000,
   parameter int PAYLOAD_BITS    = 11,
   parameter int FRAME_BYTES     = 25,
   parameter int SHIFT_REG_LEN   = 200,
   parameter int FAILSAFE_FRAMES = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     echo_valid,
   input  logic [PAYLOAD_BITS-1:0]  echo_data,
   output logic                     echo_drop,
   input  logic [SHIFT_REG_LEN-1:0] frame_in,
   input  logic                     frame_in_valid,
   input  logic                     uart_tx_busy,
   output logic                     uart_tx_en,
   output logic [PAYLOAD_BITS-1:0]  uart_tx_data,
   output logic                     frame_active,
   output logic                     frame_overrun
);
   localparam int PERIOD = CLK_HZ / 1000000 * FRAME_PERIOD_US;
   localparam int TW = PERIOD > 1 ? $clog2(PERIOD) : 1;
   localparam int IW = FRAME_BYTES > 1 ? $clog2(FRAME_BYTES) : 1;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
   state_t state_q, state_d;
   logic src_q, src_d;
   logic [TW-1:0] timer_q, timer_d;
   logic pend_q, pend_d, have_q, have_d, active_q, active_d, full_q, full_d;
   logic [SHIFT_REG_LEN-1:0] shadow_q, shadow_d, tx_q, tx_d, snap;
   logic [IW-1:0] idx_q, idx_d;
   logic [PAYLOAD_BITS-1:0] ebuf_q, ebuf_d;
   logic [7:0] cur;
   logic tick, drain;

   assign tick = timer_q == TW'(PERIOD - 1);
   assign drain = state_q == WAIT_DONE && !src_q && !uart_tx_busy;
   // The tx register shifts left per byte, so the byte on air is always the top one.
   assign cur = tx_q[SHIFT_REG_LEN-1 -: 8];
   assign uart_tx_data = src_q ? PAYLOAD_BITS'({2'b11, ^cur, cur}) : ebuf_q;
   assign uart_tx_en = state_q == ISSUE && !uart_tx_busy;
   assign echo_drop = echo_valid && full_q && !drain;
   assign frame_overrun = tick && (pend_q || active_q);
   assign frame_active = active_q;

`ifdef SBUS_FAILSAFE_EN
   localparam int FW = $clog2(FAILSAFE_FRAMES + 1);
   localparam logic [SHIFT_REG_LEN-1:0] FS_MASK = SHIFT_REG_LEN'(12) << (8 * (FRAME_BYTES - 24));
   logic [FW-1:0] fs_cnt_q, fs_cnt_d;
   logic seen_q, seen_d;
   // A period only counts as silent if no frame arrived anywhere inside it.
   always_comb begin
      fs_cnt_d = fs_cnt_q;
      seen_d = seen_q;
      if (frame_in_valid) begin
         fs_cnt_d = '0;
         seen_d = 1'b1;
      end else if (tick) begin
         seen_d = 1'b0;
         if (!seen_q && fs_cnt_q != FW'(FAILSAFE_FRAMES)) fs_cnt_d = fs_cnt_q + 1'b1;
      end
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         fs_cnt_q <= '0;
         seen_q <= 1'b0;
      end else begin
         fs_cnt_q <= fs_cnt_d;
         seen_q <= seen_d;
      end
   assign snap = fs_cnt_q == FW'(FAILSAFE_FRAMES) ? shadow_q | FS_MASK : shadow_q;
`else
   assign snap = shadow_q;
`endif

   always_comb begin
      timer_d = tick ? '0 : timer_q + 1'b1;
      shadow_d = frame_in_valid ? frame_in : shadow_q;
      have_d = have_q | frame_in_valid;
      ebuf_d = ebuf_q;
      full_d = full_q & ~drain;
      if (echo_valid && !echo_drop) begin
         ebuf_d = echo_data;
         full_d = 1'b1;
      end
      state_d = state_q;
      src_d = src_q;
      pend_d = pend_q;
      active_d = active_q;
      tx_d = tx_q;
      idx_d = idx_q;
      case (state_q)
         IDLE:
            if (pend_q && have_q) begin
               state_d = ISSUE;
               src_d = 1'b1;
               tx_d = snap;
               idx_d = '0;
               active_d = 1'b1;
               pend_d = 1'b0;
            end else begin
               pend_d = 1'b0;
               if (full_q) begin
                  state_d = ISSUE;
                  src_d = 1'b0;
               end
            end
         ISSUE: if (!uart_tx_busy) state_d = WAIT_BUSY;
         WAIT_BUSY: if (uart_tx_busy) state_d = WAIT_DONE;
         WAIT_DONE:
            if (!uart_tx_busy) begin
               if (!src_q || idx_q == IW'(FRAME_BYTES - 1)) begin
                  state_d = IDLE;
                  active_d = 1'b0;
               end else begin
                  state_d = ISSUE;
                  idx_d = idx_q + 1'b1;
                  tx_d = tx_q << 8;
               end
            end
      endcase
      if (tick) pend_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         src_q <= 1'b0;
         timer_q <= '0;
         pend_q <= 1'b0;
         have_q <= 1'b0;
         active_q <= 1'b0;
         full_q <= 1'b0;
         shadow_q <= '0;
         tx_q <= '0;
         idx_q <= '0;
         ebuf_q <= '0;
      end else begin
         state_q <= state_d;
         src_q <= src_d;
         timer_q <= timer_d;
         pend_q <= pend_d;
         have_q <= have_d;
         active_q <= active_d;
         full_q <= full_d;
         shadow_q <= shadow_d;
         tx_q <= tx_d;
         idx_q <= idx_d;
         ebuf_q <= ebuf_d;
      end
endmodule

// File: tb/tb_sbus_tx_scheduler.sv
// tb_sbus_tx_scheduler: table, hand-written and randomized checks of the echo/frame transmit scheduler.
module tb_sbus_tx_scheduler;
   localparam int PW = 11, NB = 25, SL = 200;
   logic clk = 1'b0, reset = 1'b1;
   logic echo_valid = 1'b0, frame_in_valid = 1'b0, hold = 1'b0;
   logic [PW-1:0] echo_data = '0;
   logic [SL-1:0] frame_in = '0;
   logic echo_drop, uart_tx_busy, uart_tx_en, frame_active, frame_overrun;
   logic [PW-1:0] uart_tx_data;
   int tests = 0, fails = 0, cyc = 0, bcnt = 0, blen = 3;
   bit rnd_busy = 1'b0;
   logic [PW-1:0] txq[$];
   int overruns = 0, fa_rises = 0, fa_fall_cyc = 0, bfall_cyc = 0;
   logic fa_prev = 1'b0, busy_prev = 1'b0;

   sbus_tx_scheduler #(.CLK_HZ(1000000), .FRAME_PERIOD_US(100)) dut (
      .clk(clk), .reset(reset), .echo_valid(echo_valid), .echo_data(echo_data), .echo_drop(echo_drop),
      .frame_in(frame_in), .frame_in_valid(frame_in_valid), .uart_tx_busy(uart_tx_busy),
      .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data), .frame_active(frame_active),
      .frame_overrun(frame_overrun));

   always #5 clk = ~clk;

   assign uart_tx_busy = hold || bcnt != 0;
   always @(posedge clk or posedge reset)
      if (reset) begin
         bcnt <= 0;
         cyc <= 0;
      end else begin
         cyc <= cyc + 1;
         if (uart_tx_en) bcnt <= rnd_busy ? int'($urandom_range(1, 4)) : blen;
         else if (bcnt != 0) bcnt <= bcnt - 1;
      end

   always @(negedge clk) begin
      if (uart_tx_en) txq.push_back(uart_tx_data);
      if (frame_overrun) overruns++;
      if (frame_active && !fa_prev) fa_rises++;
      if (!frame_active && fa_prev) fa_fall_cyc = cyc;
      if (!uart_tx_busy && busy_prev) bfall_cyc = cyc;
      fa_prev = frame_active;
      busy_prev = uart_tx_busy;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic to_cyc(input int c);
      while (cyc < c) step();
   endtask

   task automatic do_reset();
      step();
      reset = 1'b1;
      echo_valid = 1'b0;
      frame_in_valid = 1'b0;
      hold = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic wait_fa(input logic lvl, input int bound, input string nm);
      int k = 0;
      do begin
         @(negedge clk);
         #1;
         k++;
      end while (frame_active !== lvl && k < bound);
      check(nm, frame_active, lvl);
   endtask

   function automatic logic [7:0] fb(input int v, input int k);
      if (k == 0) return 8'h0F;
      if (k >= 23) return 8'h00;
      return 8'(k * 37 + v * 91 + 5);
   endfunction

   function automatic logic [SL-1:0] mkframe(input int v);
      logic [SL-1:0] f = '0;
      for (int k = 0; k < NB; k++) f = {f[SL-9:0], fb(v, k)};
      return f;
   endfunction

   function automatic logic [PW-1:0] wd(input logic [7:0] b);
      return {2'b11, ^b, b};
   endfunction

   function automatic logic [PW-1:0] txw(input int i);
      return i < txq.size() ? txq[i] : 11'h7FF;
   endfunction

   task automatic load_frame(input int v);
      step();
      frame_in = mkframe(v);
      frame_in_valid = 1'b1;
      step();
      frame_in_valid = 1'b0;
   endtask

   typedef struct {
      logic [PW-1:0] d;
      int lat;
      logic [PW-1:0] exp_d;
   } evec_t;

   initial begin
      evec_t ev[4];
      int n0, o0, r0, lat;
      logic [PW-1:0] got;
      logic occ, sent, sb;
      logic [PW-1:0] held;
      ev[0] = '{11'h5A5, 2, 11'h5A5};
      ev[1] = '{11'h000, 2, 11'h000};
      ev[2] = '{11'h7FF, 2, 11'h7FF};
      ev[3] = '{11'h123, 2, 11'h123};

      step();
      step();
      check("reset_outputs", {uart_tx_en, uart_tx_data, frame_active, frame_overrun, echo_drop}, 0);
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_outputs", {uart_tx_en, uart_tx_data, frame_active, frame_overrun, echo_drop}, 0);

      foreach (ev[i]) begin
         step();
         echo_valid = 1'b1;
         echo_data = ev[i].d;
         lat = -1;
         got = '0;
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) check("echo_no_drop", echo_drop, 0);
            if (uart_tx_en && lat < 0) begin
               lat = k;
               got = uart_tx_data;
            end
            step();
            if (k == 0) echo_valid = 1'b0;
         end
         check("echo_latency", lat, ev[i].lat);
         check("echo_data", got, ev[i].exp_d);
      end

      rnd_busy = 1'b1;
      r0 = fa_rises;
      o0 = overruns;
      occ = 1'b0;
      sent = 1'b0;
      sb = 1'b0;
      held = '0;
      for (int i = 0; i < 1600; i++) begin
         step();
         echo_valid = i < 1500 && $urandom_range(0, 3) == 0;
         echo_data = PW'($urandom);
         @(negedge clk);
         if (occ && sent && sb && !uart_tx_busy) occ = 1'b0;
         if (uart_tx_en) begin
            check("rnd_strobe_due", {occ, sent}, 2'b10);
            check("rnd_data", uart_tx_data, held);
            sent = 1'b1;
         end else if (sent && uart_tx_busy) sb = 1'b1;
         check("rnd_drop", echo_drop, echo_valid && occ);
         if (echo_valid && !occ) begin
            occ = 1'b1;
            sent = 1'b0;
            sb = 1'b0;
            held = echo_data;
         end
      end
      echo_valid = 1'b0;
      rnd_busy = 1'b0;
      check("rnd_drained", occ, 0);
      check("no_frame_without_store", fa_rises - r0, 0);
      check("no_overrun_without_store", overruns - o0, 0);

      do_reset();
      blen = 3;
      load_frame(0);
      n0 = txq.size();
      o0 = overruns;
      wait_fa(1'b1, 200, "frame1_start");
      wait_fa(1'b0, 300, "frame1_end");
      check("frame1_count", txq.size() - n0, NB);
      for (int k = 0; k < NB; k++) check("frame1_word", txw(n0 + k), wd(fb(0, k)));
      check("frame1_first", txw(n0), 11'h60F);
      check("frame1_last", txw(n0 + NB - 1), 11'h600);
      check("active_fall_after_busy_fall", fa_fall_cyc, bfall_cyc + 1);
      check("overrun_mid_frame", overruns - o0, 1);
      wait_fa(1'b1, 20, "frame2_start");
      repeat (10) step();
      reset = 1'b1;
      #1;
      check("reset_abort", {uart_tx_en, frame_active, uart_tx_data}, 0);
      step();
      reset = 1'b0;
      r0 = fa_rises;
      n0 = txq.size();
      to_cyc(150);
      check("no_frame_after_reset", fa_rises - r0, 0);
      check("no_strobe_after_reset", txq.size() - n0, 0);

      do_reset();
      blen = 1;
      load_frame(1);
      n0 = txq.size();
      wait_fa(1'b1, 200, "frameC_start");
      repeat (4) step();
      foreach (ev[i]) if (i < 3) begin
         step();
         echo_valid = 1'b1;
         echo_data = 11'h155 + PW'(i * 11'h155);
         @(negedge clk);
         check("echo_during_frame_drop", echo_drop, i != 0);
         step();
         echo_valid = 1'b0;
         repeat (3) step();
      end
      wait_fa(1'b0, 200, "frameC_end");
      to_cyc(195);
      check("frameC_count", txq.size() - n0, NB + 1);
      check("frameC_first", txw(n0), wd(fb(1, 0)));
      check("echo_after_frame", txw(n0 + NB), 11'h155);

      to_cyc(299);
      echo_valid = 1'b1;
      echo_data = 11'h3C3;
      n0 = txq.size();
      @(negedge clk);
      check("tick_echo_no_drop", echo_drop, 0);
      step();
      echo_valid = 1'b0;
      to_cyc(390);
      check("tick_echo_count", txq.size() - n0, NB + 1);
      check("tick_frame_first", txw(n0), wd(fb(1, 0)));
      check("tick_frame_last", txw(n0 + NB - 1), wd(fb(1, NB - 1)));
      check("tick_echo_after", txw(n0 + NB), 11'h3C3);

      to_cyc(385);
      hold = 1'b1;
      n0 = txq.size();
      o0 = overruns;
      r0 = fa_rises;
      to_cyc(510);
      check("hold_overrun", overruns - o0, 1);
      check("hold_no_strobe", txq.size() - n0, 0);
      check("hold_one_frame_started", fa_rises - r0, 1);
      hold = 1'b0;
      to_cyc(598);
      check("one_extra_frame", fa_rises - r0, 2);
      check("no_further_overrun", overruns - o0, 1);

`ifdef SBUS_FAILSAFE_EN
      do_reset();
      blen = 1;
      load_frame(0);
      for (int f = 1; f <= 6; f++) begin
         if (f == 6) begin
            to_cyc(585);
            frame_in_valid = 1'b1;
            step();
            frame_in_valid = 1'b0;
         end
         n0 = txq.size();
         wait_fa(1'b1, 150, "fs_frame_start");
         wait_fa(1'b0, 150, "fs_frame_end");
         check("fs_byte23", txw(n0 + 23), f == 5 ? 11'h60C : 11'h600);
         check("fs_byte22", txw(n0 + 22), wd(fb(0, 22)));
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
